// File: rtl/sha_pkg.sv
// sha_pkg: shared widths, memory timing and controller state encoding
// for the nonce sweep controller.
package sha_pkg;
    localparam int SHA_WORDS      = 8;
    localparam int MEM_RD_LATENCY = 2;
    localparam int WORD_W         = 32;
    localparam int ADDR_W         = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_COPY_RD,
        S_COPY_WAIT,
        S_COPY_WR,
        S_NONCE_WR,
        S_KICK,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_DATA,
        S_CHECK
    } ctl_state_t;
endpackage

// File: rtl/nonce_sweep_ctrl.sv
// nonce_sweep_ctrl: drives a shared-memory SHA-256 hasher over a range of nonces,
// stopping on the first digest whose h0 is below target.
module nonce_sweep_ctrl
    import sha_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20,
    parameter int NONCE_WORD   = 19,
    parameter int HASH_WORDS   = SHA_WORDS
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            header_addr,
    input  logic [ADDR_W-1:0]            msg_addr,
    input  logic [ADDR_W-1:0]            hash_addr,
    input  logic [WORD_W-1:0]            nonce_base,
    input  logic [WORD_W-1:0]            nonce_count,
    input  logic [WORD_W-1:0]            target,
    output logic                         done,
    output logic                         found,
    output logic [WORD_W-1:0]            found_nonce,
    output logic [HASH_WORDS*WORD_W-1:0] found_hash,
    output logic [WORD_W-1:0]            nonces_tried,
    output logic                         sha_start,
    input  logic                         sha_done,
    output logic [ADDR_W-1:0]            sha_message_addr,
    output logic [ADDR_W-1:0]            sha_output_addr,
    output logic                         mem_sel,
    output logic                         mem_clk,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [WORD_W-1:0]            mem_write_data,
    input  logic [WORD_W-1:0]            mem_read_data
);
    localparam int IDX_W = $clog2(NUM_OF_WORDS);
    localparam int DIG_W = HASH_WORDS * WORD_W;
    localparam logic [IDX_W-1:0] LAST_HDR  = IDX_W'(NONCE_WORD - 1);
    localparam logic [IDX_W-1:0] LAST_HASH = IDX_W'(HASH_WORDS - 1);
    localparam logic [1:0]       LAST_WAIT = 2'(MEM_RD_LATENCY - 2);

    ctl_state_t        r_state, w_next;
    logic [IDX_W-1:0]  r_idx;
    logic [1:0]        r_wait;
    logic [ADDR_W-1:0] r_hdr, r_msg, r_hash;
    logic [WORD_W-1:0] r_count, r_target, r_nonce, r_tried, r_found_nonce;
    logic [DIG_W-1:0]  r_digest, r_found_hash;
    logic              r_found, r_mem_sel, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_mem_wdata;
    logic              w_hit, w_last_nonce, w_wait_done, w_done, w_sha_start;

    assign w_hit        = r_digest[DIG_W-1 -: WORD_W] < r_target;
    assign w_last_nonce = (r_tried + 32'd1) == r_count;
    assign w_wait_done  = r_wait == LAST_WAIT;

    always_comb begin
        w_next      = r_state;
        w_done      = r_state == S_IDLE;
        w_sha_start = r_state == S_KICK;
        case (r_state)
            S_IDLE:      if (start && nonce_count != '0) w_next = S_COPY_RD;
            S_COPY_RD:   w_next = S_COPY_WAIT;
            S_COPY_WAIT: if (w_wait_done) w_next = S_COPY_WR;
            S_COPY_WR:   w_next = (r_idx == LAST_HDR) ? S_NONCE_WR : S_COPY_RD;
            S_NONCE_WR:  w_next = S_KICK;
            S_KICK:      w_next = S_WAIT_LOW;
            S_WAIT_LOW:  if (!sha_done) w_next = S_WAIT_HIGH;
            S_WAIT_HIGH: if (sha_done) w_next = S_RD_ADDR;
            S_RD_ADDR:   w_next = S_RD_WAIT;
            S_RD_WAIT:   if (w_wait_done) w_next = S_RD_DATA;
            S_RD_DATA:   w_next = (r_idx == LAST_HASH) ? S_CHECK : S_RD_ADDR;
            S_CHECK:     w_next = (w_hit || w_last_nonce) ? S_IDLE : S_NONCE_WR;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // One index/wait sequencer is shared by the header copy and the digest read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx         <= '0;
            r_wait        <= '0;
            r_hdr         <= '0;
            r_msg         <= '0;
            r_hash        <= '0;
            r_count       <= '0;
            r_target      <= '0;
            r_nonce       <= '0;
            r_tried       <= '0;
            r_digest      <= '0;
            r_found       <= 1'b0;
            r_found_nonce <= '0;
            r_found_hash  <= '0;
            r_mem_sel     <= 1'b1;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_hdr         <= header_addr;
                    r_msg         <= msg_addr;
                    r_hash        <= hash_addr;
                    r_count       <= nonce_count;
                    r_target      <= target;
                    r_nonce       <= nonce_base;
                    r_tried       <= '0;
                    r_found       <= 1'b0;
                    r_found_nonce <= '0;
                    r_found_hash  <= '0;
                    r_idx         <= '0;
                end
                S_COPY_RD: begin
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= r_hdr + ADDR_W'(r_idx);
                    r_wait     <= '0;
                end
                S_COPY_WAIT, S_RD_WAIT: r_wait <= r_wait + 2'd1;
                S_COPY_WR: begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_msg + ADDR_W'(r_idx);
                    r_mem_wdata <= mem_read_data;
                    r_idx       <= (r_idx == LAST_HDR) ? '0 : r_idx + 1'b1;
                end
                S_NONCE_WR: begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_msg + ADDR_W'(NONCE_WORD);
                    r_mem_wdata <= r_nonce;
                end
                S_KICK: begin
                    r_mem_sel <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
                S_WAIT_HIGH: if (sha_done) begin
                    r_mem_sel <= 1'b1;
                    r_idx     <= '0;
                end
                S_RD_ADDR: begin
                    r_mem_addr <= r_hash + ADDR_W'(r_idx);
                    r_wait     <= '0;
                end
                S_RD_DATA: begin
                    r_digest <= {r_digest[DIG_W-WORD_W-1:0], mem_read_data};
                    r_idx    <= r_idx + 1'b1;
                end
                S_CHECK: begin
                    r_tried <= r_tried + 32'd1;
                    if (w_hit) begin
                        r_found       <= 1'b1;
                        r_found_nonce <= r_nonce;
                        r_found_hash  <= r_digest;
                    end else if (!w_last_nonce) begin
                        r_nonce <= r_nonce + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done             = w_done;
    assign sha_start        = w_sha_start;
    assign found            = r_found;
    assign found_nonce      = r_found_nonce;
    assign found_hash       = r_found_hash;
    assign nonces_tried     = r_tried;
    assign sha_message_addr = r_msg;
    assign sha_output_addr  = r_hash;
    assign mem_sel          = r_mem_sel;
    assign mem_clk          = clk;
    assign mem_we           = r_mem_we;
    assign mem_addr         = r_mem_addr;
    assign mem_write_data   = r_mem_wdata;
endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// tb_nonce_sweep_ctrl: controller against a shared memory and a behavioural
// SHA-256 hasher; sweep results are predicted by a reference model and queued.
module tb_nonce_sweep_ctrl;
    localparam logic [15:0] HDR = 16'h0010, MSG = 16'h0040, HSH = 16'h0080;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    typedef struct packed {
        logic         found;
        logic [31:0]  nonce;
        logic [255:0] hash;
        logic [31:0]  tried;
        logic [31:0]  last;
    } exp_t;

    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [15:0] header_addr = HDR, msg_addr = MSG, hash_addr = HSH;
    logic [31:0] nonce_base = '0, nonce_count = '0, target = '0;
    logic done, found, sha_start, mem_sel, mem_clk, mem_we;
    logic [31:0] found_nonce, nonces_tried, mem_write_data, mem_read_data;
    logic [255:0] found_hash;
    logic [15:0] sha_message_addr, sha_output_addr, mem_addr;
    logic sha_done = 1'b1;

    logic [31:0] mem [256];
    logic [607:0] hdr_p;
    logic ld_en = 1'b0, ld_we = 1'b0, h_we = 1'b0, mon_en = 1'b0;
    logic [15:0] ld_addr = '0, h_addr = '0, m_addr;
    logic [31:0] ld_wd = '0, h_wd = '0, m_wd;
    logic m_we;
    int h_st = 0, h_cnt = 0;
    logic [255:0] h_dig = '0;
    int n_cmp = 0, n_err = 0, own_err = 0, start_cnt = 0, copy_wr = 0, done_low = 0;
    exp_t sb [$];

    nonce_sweep_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .header_addr(header_addr),
        .msg_addr(msg_addr), .hash_addr(hash_addr), .nonce_base(nonce_base),
        .nonce_count(nonce_count), .target(target), .done(done), .found(found),
        .found_nonce(found_nonce), .found_hash(found_hash), .nonces_tried(nonces_tried),
        .sha_start(sha_start), .sha_done(sha_done), .sha_message_addr(sha_message_addr),
        .sha_output_addr(sha_output_addr), .mem_sel(mem_sel), .mem_clk(mem_clk),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data));

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_blk(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96], f + hin[95:64], g + hin[63:32], h + hin[31:0]};
    endfunction

    // 80-byte message: first block is words 0..15, second holds words 16..19 plus padding.
    function automatic logic [255:0] sha20(input logic [639:0] m);
        logic [255:0] hs;
        hs = sha_blk(H0, m[639:128]);
        return sha_blk(hs, {m[127:0], 32'h8000_0000, 288'b0, 64'd640});
    endfunction

    function automatic logic [639:0] mem_msg(input logic [15:0] base);
        logic [639:0] m;
        for (int i = 0; i < 20; i++) m[639 - 32*i -: 32] = mem[8'(base + 16'(i))];
        return m;
    endfunction

    assign m_addr = ld_en ? ld_addr : (mem_sel ? mem_addr : h_addr);
    assign m_we   = ld_en ? ld_we   : (mem_sel ? mem_we   : h_we);
    assign m_wd   = ld_en ? ld_wd   : (mem_sel ? mem_write_data : h_wd);

    always @(posedge clk) begin
        if (m_we) mem[m_addr[7:0]] <= m_wd;
        mem_read_data <= mem[m_addr[7:0]];
    end

    // Hasher: done stays high 3 cycles after start, then drops while it hashes and writes.
    always @(posedge clk) begin
        case (h_st)
            0: if (sha_start) begin h_st <= 1; h_cnt <= 0; end
            1: if (h_cnt == 2) begin h_st <= 2; sha_done <= 1'b0; end else h_cnt <= h_cnt + 1;
            2: begin h_dig <= sha20(mem_msg(sha_message_addr)); h_st <= 3; h_cnt <= 0; end
            3: begin
                h_we   <= 1'b1;
                h_addr <= sha_output_addr + 16'(h_cnt);
                h_wd   <= h_dig[255 - 32*h_cnt -: 32];
                if (h_cnt == 7) h_st <= 4; else h_cnt <= h_cnt + 1;
            end
            default: begin h_we <= 1'b0; sha_done <= 1'b1; h_st <= 0; end
        endcase
    end

    always @(posedge clk) begin
        if (mon_en && ((h_st != 0 && mem_sel) || (!mem_sel && mem_we))) own_err++;
        if (sha_start) start_cnt++;
        if (!done) done_low++;
        if (mem_sel && mem_we && mem_addr >= MSG && mem_addr < MSG + 16'd19) copy_wr++;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [31:0] base, input logic [31:0] cnt, input logic [31:0] tgt);
        exp_t e, p;
        logic [31:0] n;
        logic [255:0] h;
        int s_st, s_cw, s_dl, cyc, mism;
        e = '0;
        n = base;
        for (int k = 0; k < int'(cnt); k++) begin
            h = sha20({hdr_p, n});
            e.tried = e.tried + 32'd1;
            e.last  = n;
            if (h[255:224] < tgt) begin
                e.found = 1'b1; e.nonce = n; e.hash = h;
                break;
            end
            n = n + 32'd1;
        end
        sb.push_back(e);
        s_st = start_cnt; s_cw = copy_wr; s_dl = done_low;
        @(negedge clk);
        nonce_base = base; nonce_count = cnt; target = tgt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        if (cnt == 0) repeat (20) @(negedge clk);
        while (done !== 1'b1 && cyc < 20000) begin @(negedge clk); cyc++; end
        if (cyc >= 20000) check("sweep_timeout", 256'(cyc), 0);
        p = sb.pop_front();
        mism = 0;
        for (int i = 0; i < 19; i++) if (mem[8'(MSG + 16'(i))] !== hdr_p[607 - 32*i -: 32]) mism++;
        check("found", found, p.found);
        check("found_nonce", found_nonce, p.nonce);
        check("found_hash", found_hash, p.hash);
        check("nonces_tried", nonces_tried, p.tried);
        check("sha_start_pulses", 256'(start_cnt - s_st), p.tried);
        check("header_copy_writes", 256'(copy_wr - s_cw), (cnt == 0) ? 0 : 19);
        check("msg_header_match", 256'(mism), 0);
        check("done_after", done, 1);
        if (cnt != 0) check("nonce_word", mem[8'(MSG + 16'd19)], p.last);
        else check("done_low_cycles", 256'(done_low - s_dl), 0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 19; i++) hdr_p[607 - 32*i -: 32] = 32'hA5A5_1234 ^ (32'(i) * 32'h0101_0107);
        ld_en = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            ld_we = 1'b1; ld_addr = HDR + 16'(i); ld_wd = hdr_p[607 - 32*i -: 32];
        end
        @(negedge clk);
        ld_we = 1'b0; ld_en = 1'b0;
        check("rst_done", done, 1);
        check("rst_found", found, 0);
        check("rst_found_nonce", found_nonce, 0);
        check("rst_found_hash", found_hash, 0);
        check("rst_nonces_tried", nonces_tried, 0);
        check("rst_sha_start", sha_start, 0);
        check("rst_mem_sel", mem_sel, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_write_data, 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (2) @(negedge clk);

        run(32'd5, 32'd4, 32'hFFFF_FFFF);
        run(32'd9, 32'd0, 32'hFFFF_FFFF);
        run(32'hFFFF_FFFE, 32'd3, 32'd0);
        run(32'd100, 32'd6, 32'h8000_0000);
        run(32'd7, 32'd3, 32'h1000_0000);

        // Abort a sweep while the hasher is busy and the controller waits for done.
        @(negedge clk);
        nonce_base = 32'd40; nonce_count = 32'd2; target = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (h_st != 3 && cyc < 2000) begin @(negedge clk); cyc++; end
        if (cyc >= 2000) check("abort_wait_timeout", 256'(cyc), 0);
        @(negedge clk);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("abort_done", done, 1);
        check("abort_mem_sel", mem_sel, 1);
        check("abort_sha_start", sha_start, 0);
        check("abort_nonces_tried", nonces_tried, 0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        while (h_st != 0 && cyc < 2000) begin @(negedge clk); cyc++; end
        if (cyc >= 2000) check("hasher_idle_timeout", 256'(cyc), 0);
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        run(32'd21, 32'd2, 32'hFFFF_FFFF);

        check("mem_ownership", 256'(own_err), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
